// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// Module   : pipeline_stall_ctrl
// Purpose  : Pipeline latch enable/flush sequencer with memory-stall, load-use
//            and branch-squash handling plus a sticky halt.
// Option   : PIPELINE_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             MemRead_ex,
  input  logic [REG_W-1:0] regWSEL_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             pcsrc_mem,
  input  logic             halt_wb,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             flush_mw,
  output logic             halt
`ifdef PIPELINE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t r_state, w_state_nx;
  logic   r_mem_done, w_mem_done_nx;
  logic   w_mem_op, w_mem_ok, w_active, w_adv, w_load_use;

  assign w_mem_op   = dmemREN_mem | dmemWEN_mem;
  assign w_mem_ok   = !w_mem_op | dhit | r_mem_done;
  // MEM_WAIT only marks the stall; the pipeline moves on the dhit cycle itself.
  assign w_active   = (r_state != HALTED);
  assign w_adv      = ihit & w_mem_ok & w_active;
  assign w_load_use = MemRead_ex & (regWSEL_ex != '0) &
                      ((regWSEL_ex == rs_id) | (regWSEL_ex == rt_id));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= RUN;
      r_mem_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_mem_done <= w_mem_done_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_mem_done_nx = r_mem_done;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    pc_en         = 1'b0;
    en_fd         = 1'b0;
    en_de         = 1'b0;
    en_em         = 1'b0;
    en_mw         = 1'b0;
    flush_fd      = 1'b0;
    flush_de      = 1'b0;
    flush_em      = 1'b0;
    flush_mw      = 1'b0;
    halt          = (r_state == HALTED);

    case (r_state)
      RUN:      if (w_mem_op && !dhit && !r_mem_done) w_state_nx = MEM_WAIT;
      MEM_WAIT: if (dhit) w_state_nx = RUN;
      HALTED:   w_state_nx = HALTED;
      default:  w_state_nx = RUN;
    endcase
    if (halt_wb) w_state_nx = HALTED;

    // Remember a completed access so it is not reissued while fetch stalls.
    if (w_adv)     w_mem_done_nx = 1'b0;
    else if (dhit) w_mem_done_nx = 1'b1;

    dmemREN = dmemREN_mem & !r_mem_done & w_active;
    dmemWEN = dmemWEN_mem & !r_mem_done & w_active;

    if (w_adv) begin
      en_de = 1'b1;
      en_em = 1'b1;
      en_mw = 1'b1;
      if (pcsrc_mem) begin
        pc_en    = 1'b1;
        en_fd    = 1'b1;
        flush_fd = 1'b1;
        flush_de = 1'b1;
        flush_em = 1'b1;
      end else if (w_load_use) begin
        flush_de = 1'b1;
      end else begin
        pc_en = 1'b1;
        en_fd = 1'b1;
      end
    end
  end

`ifdef PIPELINE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (w_active) begin
      if (!w_adv)                stall_cnt <= stall_cnt + 1'b1;
      if (w_adv && pcsrc_mem)    flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Purpose  : Self-checking bench for pipeline_stall_ctrl (table, directed
//            sequences, random stimulus vs. reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;

  typedef struct packed {
    logic       ihit, dhit, ren, wen, mr;
    logic [4:0] wsel, rs, rt;
    logic       pcsrc, hwb;
  } in_t;

  typedef struct {
    in_t         in;
    logic [11:0] exp;
    string       name;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST;
  in_t  cur;
  logic dmemREN, dmemWEN, pc_en, en_fd, en_de, en_em, en_mw;
  logic flush_fd, flush_de, flush_em, flush_mw, halt;
`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: halted flag, completed-access flag, counters.
  bit          m_halted, m_done;
  logic [31:0] m_stall, m_flush;

  always #5 CLK = ~CLK;

  pipeline_stall_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(cur.ihit), .dhit(cur.dhit),
    .dmemREN_mem(cur.ren), .dmemWEN_mem(cur.wen), .MemRead_ex(cur.mr),
    .regWSEL_ex(cur.wsel), .rs_id(cur.rs), .rt_id(cur.rt),
    .pcsrc_mem(cur.pcsrc), .halt_wb(cur.hwb),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pc_en(pc_en),
    .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
    .flush_mw(flush_mw), .halt(halt)
`ifdef PIPELINE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [11:0] actual();
    return {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de,
            flush_em, flush_mw, dmemREN, dmemWEN, halt};
  endfunction

  function automatic bit model_adv(in_t v);
    return v.ihit && (!(v.ren || v.wen) || v.dhit || m_done) && !m_halted;
  endfunction

  function automatic logic [11:0] model_out(in_t v);
    logic [11:0] o;
    bit lu;
    if (m_halted) return 12'b0000_0000_0001;
    lu = v.mr && v.wsel != 0 && (v.wsel == v.rs || v.wsel == v.rt);
    o = '0;
    o[2] = v.ren && !m_done;
    o[1] = v.wen && !m_done;
    if (model_adv(v)) begin
      if (v.pcsrc)   o[11:3] = 9'b11111_1110;
      else if (lu)   o[11:3] = 9'b00111_0100;
      else           o[11:3] = 9'b11111_0000;
    end
    return o;
  endfunction

  function automatic void model_update(in_t v);
    bit go;
    go = model_adv(v);
    if (!m_halted) begin
      if (!go) m_stall = m_stall + 1;
      if (go && v.pcsrc) m_flush = m_flush + 1;
    end
    if (go) m_done = 0;
    else if (v.dhit) m_done = 1;
    if (v.hwb) m_halted = 1;
  endfunction

  function automatic void model_reset();
    m_halted = 0; m_done = 0; m_stall = 0; m_flush = 0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm);
    check(nm, {20'd0, actual()}, {20'd0, model_out(cur)});
`ifdef PIPELINE_PERF_CNT_EN
    check({nm, "_stall_cnt"}, stall_cnt, m_stall);
    check({nm, "_flush_cnt"}, flush_cnt, m_flush);
`endif
  endtask

  // Inputs change 1 time unit after posedge; outputs are compared at negedge.
  task automatic step(in_t v, string nm);
    cur = v;
    @(negedge CLK);
    check_all(nm);
    @(posedge CLK);
    model_update(v);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    model_reset();
    check_all("in_reset");
    #2;
    nRST = 1'b1;
    @(posedge CLK);
    model_update(cur);
    #1;
  endtask

  function automatic in_t mk(bit ih, bit dh, bit rd, bit wr, bit pc, bit hw);
    in_t v;
    v = '0;
    v.ihit = ih; v.dhit = dh; v.ren = rd; v.wen = wr; v.pcsrc = pc; v.hwb = hw;
    return v;
  endfunction

  function automatic in_t mk_lu(bit mr, logic [4:0] w, logic [4:0] s, logic [4:0] t, bit pc);
    in_t v;
    v = mk(1, 0, 0, 0, pc, 0);
    v.mr = mr; v.wsel = w; v.rs = s; v.rt = t;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    int halted_cycles;
    in_t r;
    nRST = 1'b0;
    cur  = '0;
    model_reset();

    // Order: pc_en en_fd en_de en_em en_mw | flush fd de em mw | REN WEN halt
    tbl[0]  = '{mk(0,0,0,0,0,0),       12'b00000_0000_000, "reset_idle"};
    tbl[1]  = '{mk(1,0,0,0,0,0),       12'b11111_0000_000, "run_normal"};
    tbl[2]  = '{mk(1,0,1,0,0,0),       12'b00000_0000_100, "load_miss"};
    tbl[3]  = '{mk(1,1,1,0,0,0),       12'b11111_0000_100, "load_hit"};
    tbl[4]  = '{mk(1,1,0,1,0,0),       12'b11111_0000_010, "store_hit"};
    tbl[5]  = '{mk_lu(1,8,3,8,0),      12'b00111_0100_000, "load_use_rt"};
    tbl[6]  = '{mk_lu(1,0,0,0,0),      12'b11111_0000_000, "load_use_r0"};
    tbl[7]  = '{mk_lu(1,8,8,2,0),      12'b00111_0100_000, "load_use_rs"};
    tbl[8]  = '{mk_lu(1,8,3,8,1),      12'b11111_1110_000, "branch_over_lu"};
    tbl[9]  = '{mk(0,0,0,0,1,0),       12'b00000_0000_000, "branch_no_ihit"};
    tbl[10] = '{mk(1,0,0,0,0,1),       12'b11111_0000_000, "halt_wb_same_cyc"};
    tbl[11] = '{mk_lu(0,8,3,8,0),      12'b11111_0000_000, "no_memread"};

    #3;
    for (int i = 0; i < 12; i++) begin
      cur = tbl[i].in;
      #1;
      check(tbl[i].name, {20'd0, actual()}, {20'd0, tbl[i].exp});
    end
    cur = '0;
    reset_dut();

    for (int i = 0; i < 3; i++) step(mk(1,0,0,0,0,0), "normal_run");

    for (int i = 0; i < 3; i++) step(mk(1,0,1,0,0,0), "mem_wait");
    step(mk(1,1,1,0,0,0), "mem_wait_hit");
    step(mk(1,0,0,0,0,0), "after_wait");

    step(mk(0,1,1,0,0,0), "done_set");
    step(mk(0,0,1,0,0,0), "done_hold");
    step(mk(0,0,1,0,0,0), "done_hold");
    step(mk(1,0,1,0,0,0), "done_adv");
    step(mk(1,0,1,0,0,0), "done_cleared");
    step(mk(1,1,1,0,0,0), "done_reissue_hit");

    step(mk_lu(1,8,3,8,0), "lu_stall");
    step(mk(1,0,0,0,0,0), "lu_next");
    step(mk_lu(1,8,3,8,1), "lu_branch");

    step(mk(1,0,1,0,0,0), "halt_pre_wait");
    step(mk(1,0,1,0,0,0), "halt_pre_wait");
    step(mk(1,0,1,0,0,1), "halt_req");
    for (int i = 0; i < 4; i++) step(mk(1,1,1,1,1,0), "halted_hold");
    reset_dut();
    step(mk(1,0,0,0,0,0), "after_halt_reset");

    step(mk(1,0,1,0,0,0), "rst_mid_wait");
    step(mk(1,0,1,0,0,0), "rst_mid_wait");
    reset_dut();
    step(mk(1,1,1,0,0,0), "after_rst_wait");

    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      r = '0;
      r.ihit  = ($urandom_range(0, 3) != 0);
      r.dhit  = ($urandom_range(0, 2) == 0);
      r.ren   = ($urandom_range(0, 3) == 0);
      r.wen   = !r.ren && ($urandom_range(0, 5) == 0);
      r.mr    = $urandom_range(0, 1);
      r.wsel  = 5'($urandom_range(0, 3));
      r.rs    = 5'($urandom_range(0, 3));
      r.rt    = 5'($urandom_range(0, 3));
      r.pcsrc = ($urandom_range(0, 5) == 0);
      r.hwb   = ($urandom_range(0, 199) == 0);
      step(r, "random");
      if (m_halted) halted_cycles++;
      if (halted_cycles > 4) begin
        halted_cycles = 0;
        reset_dut();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
